data_mem_mmio: RTL and testbench

//  Data-side memory for the single-cycle RV32 core: sits directly downstream of the core's data port and

---
 rtl/data_mem_mmio.sv | 175 +++++++++++++++++
 tb/tb_data_mem_mmio.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/data_mem_mmio.sv
// ============================================================================
// data_mem_mmio : single-cycle data RAM with byte/half/word lanes plus MMIO
//                 (timer/compare irq, misalign fault capture, GPIO out)
// Revision 1.0
// ============================================================================
`default_nettype none

module data_mem_mmio #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] MMIO_BASE   = 32'h0000_F000,
  parameter int unsigned GPIO_W      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       Data_addr,
  input  logic [31:0]       write_data,
  input  logic              mem_write,
  input  logic [1:0]        length,
  output logic [31:0]       read_data,
  output logic              irq,
  output logic [GPIO_W-1:0] gpio_out
);

  localparam int unsigned AW        = $clog2(DEPTH_WORDS);
  localparam logic [31:0] RAM_BYTES = 32'(4 * DEPTH_WORDS);
  localparam logic [31:0] MMIO_END  = MMIO_BASE + 32'h20;
  localparam logic [1:0]  LEN_B     = 2'b00;
  localparam logic [1:0]  LEN_H     = 2'b01;
  localparam logic [1:0]  LEN_W     = 2'b10;
  localparam logic [2:0]  REG_TIMER = 3'd0;
  localparam logic [2:0]  REG_TCMP  = 3'd1;
  localparam logic [2:0]  REG_STAT  = 3'd2;
  localparam logic [2:0]  REG_FADDR = 3'd3;
  localparam logic [2:0]  REG_GPIO  = 3'd4;

  logic [31:0] mem [DEPTH_WORDS];

  logic [31:0]       timer_q, timer_d;
  logic [31:0]       timecmp_q, timecmp_d;
  logic              tmatch_q, tmatch_d;
  logic              misalign_q, misalign_d;
  logic [31:0]       fault_addr_q, fault_addr_d;
  logic [GPIO_W-1:0] gpio_q, gpio_d;

  logic          w_in_ram, w_in_mmio, w_len_bad, w_fault;
  logic          w_ram_we, w_mmio_we;
  logic [AW-1:0] w_word_idx;
  logic [2:0]    w_reg;
  logic [3:0]    w_be;
  logic [31:0]   w_wdata, w_ram_word, w_shifted, w_ram_rd, w_mmio_rd;

  always_comb begin
    w_in_ram   = Data_addr < RAM_BYTES;
    w_in_mmio  = !w_in_ram && (Data_addr >= MMIO_BASE) && (Data_addr < MMIO_END);
    w_len_bad  = ((length == LEN_H) && Data_addr[0]) ||
                 ((length == LEN_W) && (Data_addr[1:0] != 2'b00)) ||
                 (length == 2'b11);
    // MMIO registers only accept aligned word accesses; anything else faults
    w_fault    = (w_in_ram && w_len_bad) ||
                 (w_in_mmio && ((length != LEN_W) || (Data_addr[1:0] != 2'b00)));
    w_word_idx = Data_addr[AW+1:2];
    w_reg      = Data_addr[4:2];
    // rst gates the store so an edge seen while in reset never commits a write
    w_ram_we   = rst && mem_write && w_in_ram && !w_len_bad;
    w_mmio_we  = mem_write && w_in_mmio && !w_fault;

    w_be    = 4'b1111;
    w_wdata = write_data;
    case (length)
      LEN_B: begin
        w_be    = 4'b0001 << Data_addr[1:0];
        w_wdata = {4{write_data[7:0]}};
      end
      LEN_H: begin
        w_be    = Data_addr[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{write_data[15:0]}};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (w_ram_we && w_be[b]) begin
        mem[w_word_idx][8*b +: 8] <= w_wdata[8*b +: 8];
      end
    end
  end

  always_comb begin
    w_ram_word = mem[w_word_idx];
    w_shifted  = w_ram_word >> {Data_addr[1:0], 3'b000};
    case (length)
      LEN_B:   w_ram_rd = {24'b0, w_shifted[7:0]};
      LEN_H:   w_ram_rd = {16'b0, w_shifted[15:0]};
      default: w_ram_rd = w_ram_word;
    endcase

    case (w_reg)
      REG_TIMER: w_mmio_rd = timer_q;
      REG_TCMP:  w_mmio_rd = timecmp_q;
      REG_STAT:  w_mmio_rd = {30'b0, misalign_q, tmatch_q};
      REG_FADDR: w_mmio_rd = fault_addr_q;
      REG_GPIO:  w_mmio_rd = {{(32-GPIO_W){1'b0}}, gpio_q};
      default:   w_mmio_rd = 32'b0;
    endcase

    if (w_fault) begin
      read_data = 32'b0;
    end else if (w_in_ram) begin
      read_data = w_ram_rd;
    end else if (w_in_mmio) begin
      read_data = w_mmio_rd;
    end else begin
      read_data = 32'b0;
    end
  end

  always_comb begin
    timer_d      = timer_q + 32'd1;
    timecmp_d    = timecmp_q;
    tmatch_d     = tmatch_q;
    misalign_d   = misalign_q;
    fault_addr_d = fault_addr_q;
    gpio_d       = gpio_q;

    if (w_mmio_we) begin
      case (w_reg)
        REG_TIMER: timer_d   = write_data;
        REG_TCMP:  timecmp_d = write_data;
        REG_STAT: begin
          tmatch_d   = tmatch_q & ~write_data[0];
          misalign_d = misalign_q & ~write_data[1];
        end
        REG_GPIO:  gpio_d = write_data[GPIO_W-1:0];
        default: ;
      endcase
    end

    // Sets are applied after the W1C clear so a same-cycle set wins
    if (timer_q == timecmp_q) begin
      tmatch_d = 1'b1;
    end
    if (w_fault) begin
      misalign_d = 1'b1;
      if (!misalign_q) begin
        fault_addr_d = Data_addr;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      timer_q      <= 32'h0;
      timecmp_q    <= 32'hFFFF_FFFF;
      tmatch_q     <= 1'b0;
      misalign_q   <= 1'b0;
      fault_addr_q <= 32'h0;
      gpio_q       <= '0;
    end else begin
      timer_q      <= timer_d;
      timecmp_q    <= timecmp_d;
      tmatch_q     <= tmatch_d;
      misalign_q   <= misalign_d;
      fault_addr_q <= fault_addr_d;
      gpio_q       <= gpio_d;
    end
  end

  assign irq      = tmatch_q;
  assign gpio_out = gpio_q;

endmodule

`default_nettype wire

// File: tb/tb_data_mem_mmio.sv
// ============================================================================
// tb_data_mem_mmio : directed scoreboard bench for data_mem_mmio
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_data_mem_mmio;

  localparam int SEL_RD   = 0;
  localparam int SEL_IRQ  = 1;
  localparam int SEL_GPIO = 2;
  localparam logic [1:0] LB = 2'b00;
  localparam logic [1:0] LH = 2'b01;
  localparam logic [1:0] LW = 2'b10;
  localparam logic [31:0] IDLE_ADDR = 32'h0000_8000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] Data_addr = IDLE_ADDR;
  logic [31:0] write_data = 32'h0;
  logic        mem_write = 1'b0;
  logic [1:0]  length = LW;
  logic [31:0] read_data;
  logic        irq;
  logic [7:0]  gpio_out;

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  exp_t sb_q[$];
  exp_t m_e;
  logic [31:0] m_got;
  int n_cmp = 0;
  int n_bad = 0;

  data_mem_mmio #(
    .DEPTH_WORDS(1024),
    .MMIO_BASE  (32'h0000_F000),
    .GPIO_W     (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .Data_addr (Data_addr),
    .write_data(write_data),
    .mem_write (mem_write),
    .length    (length),
    .read_data (read_data),
    .irq       (irq),
    .gpio_out  (gpio_out)
  );

  always #5 clk = ~clk;

  // Monitor: everything queued during the current cycle is checked mid-cycle
  always @(negedge clk) begin
    while (sb_q.size() > 0) begin
      m_e = sb_q.pop_front();
      case (m_e.sel)
        SEL_IRQ:  m_got = {31'b0, irq};
        SEL_GPIO: m_got = {24'b0, gpio_out};
        default:  m_got = read_data;
      endcase
      n_cmp++;
      if (m_got !== m_e.exp) begin
        n_bad++;
        $display("FAIL %s: got %h, expected %h", m_e.name, m_got, m_e.exp);
      end
    end
  end

  task automatic push(input string n, input int sel, input logic [31:0] v);
    exp_t e;
    e.name = n;
    e.sel  = sel;
    e.exp  = v;
    sb_q.push_back(e);
  endtask

  task automatic cyc(input logic [31:0] a, input logic [31:0] wd,
                     input logic we, input logic [1:0] len);
    @(posedge clk);
    #1;
    Data_addr  = a;
    write_data = wd;
    mem_write  = we;
    length     = len;
  endtask

  task automatic ld(input logic [31:0] a, input logic [1:0] len);
    cyc(a, 32'h0, 1'b0, len);
  endtask

  task automatic st(input logic [31:0] a, input logic [31:0] d, input logic [1:0] len);
    cyc(a, d, 1'b1, len);
  endtask

  initial begin
    #200000;
    n_bad++;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset and free-running timer
    repeat (3) @(posedge clk);
    ld(32'hF000, LW);
    rst = 1'b1;
    push("rst_timer0", SEL_RD, 32'h0);
    push("rst_irq", SEL_IRQ, 32'h0);
    push("rst_gpio", SEL_GPIO, 32'h0);
    ld(32'hF000, LW); push("timer1", SEL_RD, 32'h1);
    ld(32'hF000, LW); push("timer2", SEL_RD, 32'h2);
    ld(32'hF004, LW); push("rst_timecmp", SEL_RD, 32'hFFFF_FFFF);
    ld(32'hF008, LW); push("rst_status", SEL_RD, 32'h0);

    // Lanes
    st(32'h40, 32'h1122_3344, LW);
    st(32'h41, 32'h0000_00AA, LB);
    ld(32'h42, LH); push("lh_42", SEL_RD, 32'h0000_1122);
    ld(32'h40, LW); push("lw_40", SEL_RD, 32'h1122_AA44);
    ld(32'h41, LB); push("lb_41", SEL_RD, 32'h0000_00AA);
    ld(32'h40, LB); push("lb_40", SEL_RD, 32'h0000_0044);
    ld(32'h40, LH); push("lh_40", SEL_RD, 32'h0000_AA44);

    // Misaligned
    st(32'h42, 32'h0000_DEAD, LW); push("mis_sw_rd", SEL_RD, 32'h0);
    ld(32'h40, LW); push("mis_unchanged", SEL_RD, 32'h1122_AA44);
    ld(32'hF008, LW); push("mis_status", SEL_RD, 32'h2);
    ld(32'hF00C, LW); push("mis_faddr", SEL_RD, 32'h42);
    ld(32'h45, LH); push("mis_lh_rd", SEL_RD, 32'h0);
    ld(32'hF00C, LW); push("mis_faddr_keep", SEL_RD, 32'h42);
    st(32'hF008, 32'h2, LW);
    ld(32'hF008, LW); push("mis_w1c", SEL_RD, 32'h0);
    st(32'h42, 32'h0000_BEEF, LH);
    ld(32'h40, LW); push("sh_42", SEL_RD, 32'hBEEF_AA44);

    // Timer wrap and compare
    st(32'hF000, 32'hFFFF_FFFE, LW);
    st(32'hF004, 32'h1, LW);
    ld(32'hF000, LW); push("tmr_ffff", SEL_RD, 32'hFFFF_FFFF);
    ld(32'hF000, LW); push("tmr_wrap", SEL_RD, 32'h0);
    st(32'hF008, 32'h1, LW); push("irq_pre", SEL_IRQ, 32'h0);
    st(32'hF008, 32'h1, LW);
    push("irq_set_wins", SEL_IRQ, 32'h1);
    push("status_tmatch", SEL_RD, 32'h1);
    ld(32'hF008, LW);
    push("irq_cleared", SEL_IRQ, 32'h0);
    push("status_clr", SEL_RD, 32'h0);

    // MMIO width and unmapped
    st(32'hF010, 32'h0000_005A, LB); push("gpio_sb_rd", SEL_RD, 32'h0);
    ld(32'hF008, LW);
    push("gpio_sb_status", SEL_RD, 32'h2);
    push("gpio_sb_keep", SEL_GPIO, 32'h0);
    ld(32'hF00C, LW); push("gpio_sb_faddr", SEL_RD, 32'hF010);
    st(32'hF010, 32'h0000_01A5, LW);
    ld(32'hF010, LW);
    push("gpio_rd", SEL_RD, 32'hA5);
    push("gpio_out", SEL_GPIO, 32'hA5);
    st(32'h8000, 32'h1234_5678, LW); push("unmap_sw_rd", SEL_RD, 32'h0);
    ld(32'h8000, LW); push("unmap_rd", SEL_RD, 32'h0);
    ld(32'hF014, LW); push("reserved_rd", SEL_RD, 32'h0);
    ld(32'hF00C, LW); push("unmap_nofault", SEL_RD, 32'hF010);

    // Read during write
    st(32'h80, 32'h1, LW);
    st(32'h80, 32'h2, LW); push("rdw_old", SEL_RD, 32'h1);
    ld(32'h80, LW); push("rdw_new", SEL_RD, 32'h2);

    // Asynchronous reset blocks a store issued while held
    st(32'h80, 32'h55, LW);
    rst = 1'b0;
    push("async_gpio", SEL_GPIO, 32'h0);
    push("async_irq", SEL_IRQ, 32'h0);
    ld(32'h80, LW);
    rst = 1'b1;
    push("rst_no_write", SEL_RD, 32'h2);
    ld(32'hF008, LW); push("rst_status2", SEL_RD, 32'h0);

    cyc(IDLE_ADDR, 32'h0, 1'b0, LW);
    @(negedge clk);
    #1;
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_bad++;
      $display("FAIL sb_drain: got %0d pending, expected 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
